// File: rtl/bus_fetch.sv
// bus_fetch -- instruction fetch sequencer for a multiplexed 4-bit ROM bus.
//
// Every instruction cycle is eight clocks long. The current subcycle is held
// in a free-running counter:
//   0=A1 1=A2 2=A3 3=M1 4=M2 5=X1 6=X2 7=X3
// The 12-bit fetch address goes out one nibble at a time during A1..A3. The
// ROM returns the instruction high nibble in M1 and the low nibble in M2.
//
// Ports
//   clock         rising-edge system clock
//   reset         synchronous, active-high reset
//   data          shared nibble bus; driven here only in A1..A3, high-Z otherwise
//   sync          registered, high during X3 (the next instruction cycle starts next)
//   cmd           registered ROM command strobe, high during A3
//   pc_load       jump request, sampled only at the edge that ends X3
//   pc_load_addr  jump target
//   pc            address of the next fetch
//   instr_valid   one-clock pulse during X1 when opr/opa/instr_addr are new
//   opr, opa      fetched instruction high / low nibble
//   instr_addr    fetch address of the held opr/opa
module bus_fetch #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clock,
  input  logic        reset,
  inout  wire  [3:0]  data,
  output logic        sync,
  output logic        cmd,
  input  logic        pc_load,
  input  logic [11:0] pc_load_addr,
  output logic [11:0] pc,
  output logic        instr_valid,
  output logic [3:0]  opr,
  output logic [3:0]  opa,
  output logic [11:0] instr_addr
);

  typedef enum logic [2:0] {
    A1 = 3'd0,
    A2 = 3'd1,
    A3 = 3'd2,
    M1 = 3'd3,
    M2 = 3'd4,
    X1 = 3'd5,
    X2 = 3'd6,
    X3 = 3'd7
  } subcycle_t;

  subcycle_t   state;
  subcycle_t   state_nxt;

  // Decoded per-subcycle actions, all taking effect at the edge that ends
  // the current subcycle (except drive_en/addr_nib, which act during it).
  logic        drive_en;
  logic [3:0]  addr_nib;
  logic        cap_fetch;
  logic        cap_opr;
  logic        cap_opa;
  logic        load_win;
  logic        vld_nxt;
  logic        sync_nxt;
  logic        cmd_nxt;

  // Fetch address latched at the end of A3 and only published at the end
  // of M2, so instr_addr always pairs with the opr/opa being published.
  logic [11:0] fetch_addr_p0;
  logic        vld_p1;

  // Subcycle register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= A1;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = A1;
    drive_en  = 1'b0;
    addr_nib  = pc[3:0];
    cap_fetch = 1'b0;
    cap_opr   = 1'b0;
    cap_opa   = 1'b0;
    load_win  = 1'b0;
    vld_nxt   = 1'b0;
    sync_nxt  = 1'b0;
    cmd_nxt   = 1'b0;
    case (state)
      A1: begin
        state_nxt = A2;
        drive_en  = 1'b1;
        addr_nib  = pc[3:0];
      end
      A2: begin
        state_nxt = A3;
        drive_en  = 1'b1;
        addr_nib  = pc[7:4];
        cmd_nxt   = 1'b1;
      end
      A3: begin
        state_nxt = M1;
        drive_en  = 1'b1;
        addr_nib  = pc[11:8];
        cap_fetch = 1'b1;
      end
      M1: begin
        state_nxt = M2;
        cap_opr   = 1'b1;
      end
      M2: begin
        state_nxt = X1;
        cap_opa   = 1'b1;
        vld_nxt   = 1'b1;
      end
      X1: begin
        state_nxt = X2;
      end
      X2: begin
        state_nxt = X3;
        sync_nxt  = 1'b1;
      end
      X3: begin
        state_nxt = A1;
        load_win  = 1'b1;
      end
      default: begin
        state_nxt = A1;
      end
    endcase
  end

  // The bus is released combinationally as soon as reset is seen, so an
  // aborted address phase never overlaps the ROM's own reset behaviour.
  assign data = (drive_en && !reset) ? addr_nib : 4'bzzzz;

  // Address / capture stage
  always_ff @(posedge clock) begin
    if (reset) begin
      pc            <= RESET_PC;
      fetch_addr_p0 <= 12'h000;
      opr           <= 4'h0;
      opa           <= 4'h0;
      instr_addr    <= 12'h000;
      vld_p1        <= 1'b0;
      sync          <= 1'b0;
      cmd           <= 1'b0;
    end else begin
      vld_p1 <= vld_nxt;
      sync   <= sync_nxt;
      cmd    <= cmd_nxt;
      if (cap_fetch) begin
        fetch_addr_p0 <= pc;
      end
      if (cap_opr) begin
        opr <= data;
      end
      // pc advances after the ROM has taken the address, leaving it stable
      // through the whole next address phase.
      if (cap_opa) begin
        opa        <= data;
        instr_addr <= fetch_addr_p0;
        pc         <= pc + 12'd1;
      end
      if (load_win && pc_load) begin
        pc <= pc_load_addr;
      end
    end
  end

  assign instr_valid = vld_p1;

endmodule

// File: doc/bus_fetch.md
BUS_FETCH -- requirements
Module: bus_fetch

Interface
REQ-001 Parameter: RESET_PC, 12'h000, PC value loaded on reset.
REQ-002 Port: clock  input  1  rising-edge system clock.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: data  inout  4  shared nibble bus to ROM (address out, instruction in).
REQ-005 Port: sync  output  1  high during subcycle 7, marks next instruction cycle start.
REQ-006 Port: cmd  output  1  ROM command strobe, high during subcycle 2 (A3).
REQ-007 Port: pc_load  input  1  jump request, sampled at end of subcycle 7.
REQ-008 Port: pc_load_addr  input  12  jump target.
REQ-009 Port: pc  output  12  address of next fetch.
REQ-010 Port: instr_valid  output  1  one-clock pulse, new instruction available.
REQ-011 Port: opr  output  4  fetched instruction high nibble.
REQ-012 Port: opa  output  4  fetched instruction low nibble.
REQ-013 Port: instr_addr  output  12  fetch address of held opr/opa.

Function
REQ-014 3-bit subcycle counter SHALL advance by 1 every clock, wrapping 7->0: 0=A1,1=A2,2=A3,3=M1,4=M2,5=X1,6=X2,7=X3.
REQ-015 data SHALL be driven with pc[3:0] in subcycle 0, pc[7:4] in 1, pc[11:8] in 2; high-Z in subcycles 3-7.
REQ-016 At the clock edge ending subcycle 3, opr SHALL capture data; at the edge ending subcycle 4, opa SHALL capture data.
REQ-017 At the edge ending subcycle 2, an internal fetch-address register SHALL capture pc; it SHALL be copied to instr_addr at the edge ending subcycle 4.
REQ-018 At the edge ending subcycle 4, pc SHALL increment by 1 modulo 4096 (12'hFFF -> 12'h000).
REQ-019 At the edge ending subcycle 7, if pc_load=1, pc SHALL become pc_load_addr; pc_load outside subcycle 7 SHALL be ignored.
REQ-020 pc SHALL be stable from subcycle 0 through 2 of every instruction cycle.
REQ-021 instr_valid SHALL be 1 exactly during subcycle 5, 0 otherwise; opr/opa/instr_addr SHALL hold from subcycle 5 until the next capture.
REQ-022 sync SHALL be registered, high only during subcycle 7; cmd SHALL be registered, high only during subcycle 2.
REQ-023 The block SHALL never drive data in a subcycle where the ROM drives it (3, 4); no stall mechanism exists, cycle runs free.
REQ-024 Subcycle numbering SHALL align with the ROM counter: both reach subcycle 0 on the first clock after reset deasserts.

Reset
REQ-025 While reset=1: subcycle counter=0, pc=RESET_PC, opr=0, opa=0, instr_addr=0, instr_valid=0, sync=0, cmd=0, data high-Z.
REQ-026 Reset asserted mid-cycle SHALL abort the fetch in progress; no instr_valid pulse SHALL follow for the aborted fetch.
REQ-027 First clock after reset deasserts SHALL be subcycle 0 driving RESET_PC[3:0].

Verification
REQ-028 Reset, ROM model with mem[0]=8'hA5, mem[1]=8'h3C -> instr_valid at clock 5 with opr=A, opa=5, instr_addr=0; at clock 13 opr=3, opa=C, instr_addr=1.
REQ-029 pc_load=1, pc_load_addr=12'h7F0 during subcycle 7 -> next subcycles 0-2 drive 0,F,7; instr_addr=12'h7F0 on following instr_valid.
REQ-030 pc_load=1 held in subcycles 0-6 only -> pc unaffected, sequential fetch continues.
REQ-031 Load pc=12'hFFF -> fetch from FFF then next fetch from 000 (wrap).
REQ-032 Reset asserted during subcycle 3 -> no instr_valid, data high-Z, fetch restarts at RESET_PC with sync/cmd timing per REQ-022.
REQ-033 Bus monitor over 1000 cycles -> never both block and ROM driving data; sync high exactly 1 of every 8 clocks.
